score_display_ctrl: RTL and testbench

- Counts elapsed seconds (0..9999, decimal) while `status` is high.
- Shows the count on a 4-digit multiplexed common-anode 7-segment display.
- Sits between the game/status logic and the board display pins.
- All logic runs in the `clk_100MHz` domain; `clk_1Hz` is a slow input sampled as data, not used as a clock.

---
 rtl/display_pkg.sv | 22 ++
 rtl/seg7_decoder.sv | 26 ++
 rtl/score_display_ctrl.sv | 100 ++++++++++
 tb/tb_score_display_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the 4-digit common-anode 7-segment display:
// active-low segment patterns {a,b,c,d,e,f,g} and active-low digit enables.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_D3 = 4'b0111;
    localparam logic [3:0] AN_D2 = 4'b1011;
    localparam logic [3:0] AN_D1 = 4'b1101;
    localparam logic [3:0] AN_D0 = 4'b1110;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes blank.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Elapsed-seconds counter (0..MAX_COUNT) gated by status, shown on a
// multiplexed 4-digit 7-segment display. clk_1Hz is sampled as data.
module score_display_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_BITS = 20,
    parameter int MAX_COUNT    = 9999
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       clk_1Hz,
    input  logic       status,
    output logic [3:0] Anode_Activate,
    output logic [6:0] LED_out
);

    logic                    tick_sync_p0;
    logic                    tick_sync_p1;
    logic                    tick_hist_p2;
    logic                    tick;
    logic [13:0]             displayed_number;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [1:0]              sel;
    logic [3:0]              thousands;
    logic [3:0]              hundreds;
    logic [3:0]              tens;
    logic [3:0]              ones;
    logic [3:0]              digit;
    logic [3:0]              anode_nxt;
    logic [6:0]              seg_nxt;

    // Sync/history flops reset high so a level already high at release is not an edge.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            tick_sync_p0 <= 1'b1;
            tick_sync_p1 <= 1'b1;
            tick_hist_p2 <= 1'b1;
        end else begin
            tick_sync_p0 <= clk_1Hz;
            tick_sync_p1 <= tick_sync_p0;
            tick_hist_p2 <= tick_sync_p1;
        end
    end

    assign tick = tick_sync_p1 & ~tick_hist_p2;

    // Counter stage
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            displayed_number <= 14'd0;
        end else if (tick && status) begin
            if (displayed_number == 14'(MAX_COUNT))
                displayed_number <= 14'd0;
            else
                displayed_number <= displayed_number + 14'd1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset)
            refresh_cnt <= '0;
        else
            refresh_cnt <= refresh_cnt + 1'b1;
    end

    assign sel       = refresh_cnt[REFRESH_BITS-1 -: 2];
    assign thousands = 4'(displayed_number / 14'd1000);
    assign hundreds  = 4'((displayed_number / 14'd100) % 14'd10);
    assign tens      = 4'((displayed_number / 14'd10) % 14'd10);
    assign ones      = 4'(displayed_number % 14'd10);

    always_comb begin
        anode_nxt = AN_D3;
        digit     = thousands;
        case (sel)
            2'd0: begin anode_nxt = AN_D3; digit = thousands; end
            2'd1: begin anode_nxt = AN_D2; digit = hundreds;  end
            2'd2: begin anode_nxt = AN_D1; digit = tens;      end
            2'd3: begin anode_nxt = AN_D0; digit = ones;      end
            default: begin anode_nxt = AN_D3; digit = thousands; end
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .digit (digit),
        .seg   (seg_nxt)
    );

    // Output stage: anode and segments registered together so they never disagree.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            Anode_Activate <= AN_D3;
            LED_out        <= SEG_0;
        end else begin
            Anode_Activate <= anode_nxt;
            LED_out        <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl with a shortened refresh counter.
module tb_score_display_ctrl;

    logic       clk_100MHz;
    logic       reset;
    logic       clk_1Hz;
    logic       status;
    logic [3:0] Anode_Activate;
    logic [6:0] LED_out;

    int n_checks;
    int n_errors;

    score_display_ctrl #(
        .REFRESH_BITS (4),
        .MAX_COUNT    (9999)
    ) dut (
        .clk_100MHz     (clk_100MHz),
        .reset          (reset),
        .clk_1Hz        (clk_1Hz),
        .status         (status),
        .Anode_Activate (Anode_Activate),
        .LED_out        (LED_out)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    // 2 us period tick
    task automatic slow_tick();
        @(negedge clk_100MHz);
        clk_1Hz = 1'b1;
        wait_cycles(100);
        clk_1Hz = 1'b0;
        wait_cycles(100);
    endtask

    // Fast preload tick: 2 cycles high, 2 low
    task automatic fast_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_100MHz);
            clk_1Hz = 1'b1;
            wait_cycles(2);
            clk_1Hz = 1'b0;
            wait_cycles(1);
        end
        wait_cycles(4);
    endtask

    task automatic check_digit(input string tag, input logic [3:0] an, input logic [6:0] exp_led);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_100MHz);
            if (Anode_Activate == an) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_found"}, 32'(found), 32'd1);
        if (found)
            check(tag, 32'(LED_out), 32'(exp_led));
    endtask

    logic [3:0] scan_an  [4];
    logic [6:0] scan_seg [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        clk_1Hz  = 1'b0;
        status   = 1'b0;

        wait_cycles(10);
        check("rst_count", 32'(dut.displayed_number), 32'd0);
        check("rst_anode", 32'(Anode_Activate), 32'b0111);
        check("rst_led",   32'(LED_out), 32'b0000001);

        reset  = 1'b0;
        status = 1'b1;
        repeat (3) slow_tick();
        check("count3", 32'(dut.displayed_number), 32'd3);
        check_digit("c3_ones", 4'b1110, 7'b0000110);
        check_digit("c3_thou", 4'b0111, 7'b0000001);

        status = 1'b0;
        repeat (2) slow_tick();
        check("hold", 32'(dut.displayed_number), 32'd3);
        status = 1'b1;
        slow_tick();
        check("resume", 32'(dut.displayed_number), 32'd4);

        fast_ticks(1230);
        check("count1234", 32'(dut.displayed_number), 32'd1234);
        scan_an[0] = 4'b0111; scan_seg[0] = 7'b1001111;
        scan_an[1] = 4'b1011; scan_seg[1] = 7'b0010010;
        scan_an[2] = 4'b1101; scan_seg[2] = 7'b0000110;
        scan_an[3] = 4'b1110; scan_seg[3] = 7'b1001100;
        check_digit("sync_d0", 4'b1110, 7'b1001100);
        check_digit("sync_d3", 4'b0111, 7'b1001111);
        for (int i = 0; i < 16; i++) begin
            if (i != 0) @(negedge clk_100MHz);
            check($sformatf("scan_an_%0d", i),  32'(Anode_Activate), 32'(scan_an[i/4]));
            check($sformatf("scan_led_%0d", i), 32'(LED_out),        32'(scan_seg[i/4]));
        end

        fast_ticks(8765);
        check("count9999", 32'(dut.displayed_number), 32'd9999);
        check_digit("max_d3", 4'b0111, 7'b0000100);
        check_digit("max_d2", 4'b1011, 7'b0000100);
        check_digit("max_d1", 4'b1101, 7'b0000100);
        check_digit("max_d0", 4'b1110, 7'b0000100);
        slow_tick();
        check("wrap", 32'(dut.displayed_number), 32'd0);
        check_digit("wrap_d3", 4'b0111, 7'b0000001);
        check_digit("wrap_d2", 4'b1011, 7'b0000001);
        check_digit("wrap_d1", 4'b1101, 7'b0000001);
        check_digit("wrap_d0", 4'b1110, 7'b0000001);

        // clk_1Hz already high when reset releases
        fast_ticks(5);
        @(negedge clk_100MHz);
        clk_1Hz = 1'b1;
        reset   = 1'b1;
        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(20);
        check("hi_at_release", 32'(dut.displayed_number), 32'd0);
        clk_1Hz = 1'b0;
        wait_cycles(10);
        clk_1Hz = 1'b1;
        wait_cycles(10);
        check("first_edge", 32'(dut.displayed_number), 32'd1);
        clk_1Hz = 1'b0;
        wait_cycles(10);

        fast_ticks(56);
        check("count57", 32'(dut.displayed_number), 32'd57);
        reset = 1'b1;
        @(negedge clk_100MHz);
        check("midrst_count", 32'(dut.displayed_number), 32'd0);
        check("midrst_anode", 32'(Anode_Activate), 32'b0111);
        check("midrst_led",   32'(LED_out), 32'b0000001);
        reset = 1'b0;
        wait_cycles(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
